// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker: accepts DATA_WIDTH-bit words from the render FIFO
// under a one-cycle-late credit scheme, buffers up to two words and streams
// them out as PIXEL_WIDTH-bit pixels on a valid/ready interface.
// Optional build macro: UNPACK_MSB_FIRST_EN selects MSB-first pixel order
// (default is LSB-first).
module fifo_word_unpacker #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned PIXEL_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [DATA_WIDTH-1:0]  data_line_in,
  input  logic                   data_valid_in,
  output logic                   receiver_ready_out,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   pixel_valid_out,
  input  logic                   pixel_ready_in,
  output logic                   pixel_last_out,
  output logic                   overflow_out
);

  localparam int unsigned PIXELS_PER_WORD = DATA_WIDTH / PIXEL_WIDTH;
  localparam int unsigned IDX_W = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS_PER_WORD - 1);

  // Reject configurations where pixels do not tile the word exactly.
  if ((DATA_WIDTH % PIXEL_WIDTH) != 0) begin : g_bad_width
    $error("fifo_word_unpacker: PIXEL_WIDTH must divide DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [1:0]            held_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  pending_q;
  logic                  overflow_q;
  logic                  live_q;

  logic                   accept;
  logic                   pop;
  logic [PIXEL_WIDTH-1:0] lanes [PIXELS_PER_WORD];

  // Slice the head word into pixel lanes in the configured order.
  for (genvar g = 0; g < PIXELS_PER_WORD; g++) begin : g_lane
`ifdef UNPACK_MSB_FIRST_EN
    assign lanes[g] = head_q[DATA_WIDTH-1-g*PIXEL_WIDTH -: PIXEL_WIDTH];
`else
    assign lanes[g] = head_q[g*PIXEL_WIDTH +: PIXEL_WIDTH];
`endif
  end

  // Output stream and credit derived from registered state only.
  always_comb begin
    pixel_valid_out    = (held_q != 2'd0);
    accept             = pixel_valid_out && pixel_ready_in;
    pop                = accept && (idx_q == LAST_IDX);
    pixel_out          = pixel_valid_out ? lanes[idx_q] : '0;
    pixel_last_out     = pixel_valid_out && (idx_q == LAST_IDX);
    receiver_ready_out = live_q && (({1'b0, held_q} + {2'b00, pending_q}) < 3'd2);
    overflow_out       = overflow_q;
  end

  // Buffer, pixel index, credit tracking and sticky overflow.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      held_q     <= 2'd0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      live_q    <= 1'b1;
      pending_q <= receiver_ready_out;

      if (accept) begin
        idx_q <= pop ? '0 : idx_q + 1'b1;
      end

      case ({pop, data_valid_in})
        2'b10: begin
          head_q <= tail_q;
          held_q <= held_q - 2'd1;
        end
        2'b01: begin
          if (held_q == 2'd0) begin
            head_q <= data_line_in;
            held_q <= 2'd1;
          end else if (held_q == 2'd1) begin
            tail_q <= data_line_in;
            held_q <= 2'd2;
          end else begin
            overflow_q <= 1'b1;
          end
        end
        2'b11: begin
          // Pop and push together: occupancy is unchanged.
          if (held_q == 2'd1) begin
            head_q <= data_line_in;
          end else begin
            head_q <= tail_q;
            tail_q <= data_line_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed self-checking bench for fifo_word_unpacker.
// Expected pixel order follows UNPACK_MSB_FIRST_EN when that macro is defined.
module tb_fifo_word_unpacker;

  localparam int unsigned DW  = 64;
  localparam int unsigned PW  = 16;
  localparam int unsigned PPW = 4;

  logic          clk = 1'b0;
  logic          rst_in = 1'b0;
  logic [DW-1:0] data_line_in = '0;
  logic          data_valid_in = 1'b0;
  logic          receiver_ready_out;
  logic [PW-1:0] pixel_out;
  logic          pixel_valid_out;
  logic          pixel_ready_in = 1'b0;
  logic          pixel_last_out;
  logic          overflow_out;

  int errors = 0;
  int checks = 0;

  fifo_word_unpacker #(.DATA_WIDTH(DW), .PIXEL_WIDTH(PW)) dut (
    .clk_in             (clk),
    .rst_in             (rst_in),
    .data_line_in       (data_line_in),
    .data_valid_in      (data_valid_in),
    .receiver_ready_out (receiver_ready_out),
    .pixel_out          (pixel_out),
    .pixel_valid_out    (pixel_valid_out),
    .pixel_ready_in     (pixel_ready_in),
    .pixel_last_out     (pixel_last_out),
    .overflow_out       (overflow_out)
  );

  always #5 clk = ~clk;

  // Expected pixel k of word w in the configured order.
  function automatic logic [PW-1:0] exp_pix(input logic [DW-1:0] w, input int k);
    int lane;
`ifdef UNPACK_MSB_FIRST_EN
    lane = PPW - 1 - k;
`else
    lane = k;
`endif
    exp_pix = w[lane*PW +: PW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    data_valid_in = 1'b1;
    data_line_in = 64'hDEAD_BEEF_0BAD_F00D;
    step();
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({receiver_ready_out, pixel_valid_out, pixel_last_out, overflow_out, pixel_out} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d: got rdy=%b vld=%b last=%b ovf=%b pix=%h, expected all 0",
                 c, receiver_ready_out, pixel_valid_out, pixel_last_out, overflow_out, pixel_out);
      end
      data_valid_in = 1'b0;
      step();
    end
    rst_in = 1'b1;
    step();
    checks++;
    if (receiver_ready_out !== 1'b1 || pixel_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0",
               receiver_ready_out, pixel_valid_out);
    end
  endtask

  task automatic test_single_word(input logic [DW-1:0] w);
    logic [PW-1:0] first;
    pixel_ready_in = 1'b1;
    data_line_in = w;
    data_valid_in = 1'b1;
    step();
    data_valid_in = 1'b0;
`ifdef UNPACK_MSB_FIRST_EN
    first = 16'h4444;
`else
    first = 16'h1111;
`endif
    checks++;
    if (pixel_out !== first) begin
      errors++;
      $display("FAIL single_first_pixel: got %h expected %h", pixel_out, first);
    end
    for (int k = 0; k < PPW; k++) begin
      checks++;
      if (pixel_valid_out !== 1'b1 || pixel_out !== exp_pix(w, k) || pixel_last_out !== (k == PPW - 1)) begin
        errors++;
        $display("FAIL single_pixel k=%0d: got vld=%b pix=%h last=%b expected vld=1 pix=%h last=%b",
                 k, pixel_valid_out, pixel_out, pixel_last_out, exp_pix(w, k), (k == PPW - 1));
      end
      step();
    end
    checks++;
    if (pixel_valid_out !== 1'b0 || receiver_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL single_drained: got vld=%b rdy=%b expected vld=0 rdy=1",
               pixel_valid_out, receiver_ready_out);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] words [8];
    logic prev_ready;
    int sent;
    int got;
    int errs_before;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < PPW; j++) begin
        words[k][j*PW +: PW] = 16'((k + 1) * 256 + 16 + j);
      end
    end
    prev_ready = 1'b0;
    sent = 0;
    got = 0;
    errs_before = errors;
    pixel_ready_in = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 32; cyc++) begin
      if (prev_ready && sent < 8) begin
        data_valid_in = 1'b1;
        data_line_in = words[sent];
        sent++;
      end else begin
        data_valid_in = 1'b0;
      end
      prev_ready = receiver_ready_out;
      if (pixel_valid_out) begin
        checks++;
        if (pixel_out !== exp_pix(words[got / PPW], got % PPW) || pixel_last_out !== ((got % PPW) == PPW - 1)) begin
          errors++;
          $display("FAIL stream_pixel n=%0d: got pix=%h last=%b expected pix=%h last=%b",
                   got, pixel_out, pixel_last_out, exp_pix(words[got / PPW], got % PPW),
                   ((got % PPW) == PPW - 1));
        end
        got++;
      end
      if (overflow_out !== 1'b0 && errors == errs_before) begin
        checks++;
        errors++;
        $display("FAIL stream_overflow: got %b expected 0", overflow_out);
      end
      step();
    end
    data_valid_in = 1'b0;
    checks++;
    if (got !== 32 || sent !== 8) begin
      errors++;
      $display("FAIL stream_count: got %0d pixels from %0d words, expected 32 from 8", got, sent);
    end
    checks++;
    if (overflow_out !== 1'b0 || pixel_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: got ovf=%b vld=%b expected 0 0", overflow_out, pixel_valid_out);
    end
  endtask

  task automatic test_backpressure(input logic [DW-1:0] a, input logic [DW-1:0] b);
    pixel_ready_in = 1'b0;
    data_valid_in = 1'b1;
    data_line_in = a;
    step();
    data_line_in = b;
    step();
    data_valid_in = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (receiver_ready_out !== 1'b0 || pixel_valid_out !== 1'b1 || pixel_out !== exp_pix(a, 0)) begin
        errors++;
        $display("FAIL bp_hold c=%0d: got rdy=%b vld=%b pix=%h expected rdy=0 vld=1 pix=%h",
                 c, receiver_ready_out, pixel_valid_out, pixel_out, exp_pix(a, 0));
      end
      step();
    end
    pixel_ready_in = 1'b1;
    for (int k = 0; k < 2 * PPW; k++) begin
      checks++;
      if (pixel_out !== exp_pix((k < PPW) ? a : b, k % PPW)) begin
        errors++;
        $display("FAIL bp_release k=%0d: got %h expected %h", k, pixel_out,
                 exp_pix((k < PPW) ? a : b, k % PPW));
      end
      step();
    end
    checks++;
    if (pixel_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: got vld=%b expected 0", pixel_valid_out);
    end
  endtask

  task automatic test_overflow(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c3);
    pixel_ready_in = 1'b0;
    data_valid_in = 1'b1;
    data_line_in = a;
    step();
    data_line_in = b;
    step();
    checks++;
    if (overflow_out !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before: got %b expected 0", overflow_out);
    end
    data_line_in = c3;
    step();
    data_valid_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (overflow_out !== 1'b1 || pixel_out !== exp_pix(a, 0)) begin
        errors++;
        $display("FAIL ovf_sticky c=%0d: got ovf=%b pix=%h expected ovf=1 pix=%h",
                 c, overflow_out, pixel_out, exp_pix(a, 0));
      end
      step();
    end
    pixel_ready_in = 1'b1;
    for (int k = 0; k < 2 * PPW; k++) begin
      checks++;
      if (pixel_out !== exp_pix((k < PPW) ? a : b, k % PPW)) begin
        errors++;
        $display("FAIL ovf_order k=%0d: got %h expected %h", k, pixel_out,
                 exp_pix((k < PPW) ? a : b, k % PPW));
      end
      step();
    end
    checks++;
    if (pixel_valid_out !== 1'b0 || overflow_out !== 1'b1) begin
      errors++;
      $display("FAIL ovf_dropped: got vld=%b ovf=%b expected vld=0 ovf=1", pixel_valid_out, overflow_out);
    end
  endtask

  task automatic test_reset_mid_word(input logic [DW-1:0] d, input logic [DW-1:0] e, input logic [DW-1:0] f);
    pixel_ready_in = 1'b1;
    data_valid_in = 1'b1;
    data_line_in = d;
    step();
    data_valid_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pixel_out !== exp_pix(d, k)) begin
        errors++;
        $display("FAIL mid_pre k=%0d: got %h expected %h", k, pixel_out, exp_pix(d, k));
      end
      step();
    end
    rst_in = 1'b0;
    data_valid_in = 1'b1;
    data_line_in = e;
    step();
    checks++;
    if (pixel_valid_out !== 1'b0 || overflow_out !== 1'b0 || receiver_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got vld=%b ovf=%b rdy=%b expected 0 0 0",
               pixel_valid_out, overflow_out, receiver_ready_out);
    end
    rst_in = 1'b1;
    data_valid_in = 1'b0;
    step();
    checks++;
    if (pixel_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_ignored_pulse: got vld=%b expected 0", pixel_valid_out);
    end
    data_valid_in = 1'b1;
    data_line_in = f;
    step();
    data_valid_in = 1'b0;
    checks++;
    if (pixel_valid_out !== 1'b1 || pixel_out !== exp_pix(f, 0) || pixel_last_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart: got vld=%b pix=%h last=%b expected vld=1 pix=%h last=0",
               pixel_valid_out, pixel_out, pixel_last_out, exp_pix(f, 0));
    end
    for (int k = 0; k < PPW; k++) step();
  endtask

  initial begin
    test_reset();
    test_single_word(64'h4444_3333_2222_1111);
    test_stream();
    test_backpressure(64'hA003_A002_A001_A000, 64'hB003_B002_B001_B000);
    test_overflow(64'hC003_C002_C001_C000, 64'hD003_D002_D001_D000, 64'hEEEE_EEEE_EEEE_EEEE);
    test_reset_mid_word(64'h5D03_5D02_5D01_5D00, 64'h6E03_6E02_6E01_6E00, 64'h7F03_7F02_7F01_7F00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
